// File: rtl/dram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// dram_rd_arbiter
//
// Two-master AXI read (AR/R) arbiter in front of the DRAM wrapper. Master 0
// is instruction fetch, master 1 is data/DMA. One burst is in flight at a
// time: a winner is picked in IDLE, its AR fields are registered and
// presented to the wrapper in ADDR, and the R beats are passed straight
// through to the owner in DATA.
//
// Selection prefers a request that targets the currently open DRAM row
// (address bits [24:14]) to avoid precharge/activate cycles; a streak
// counter forces the other master in after MAX_STREAK consecutive contested
// grants so neither side starves.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   m_arvalid[1:0]   per-master AR valid
//   m_arready[1:0]   per-master AR ready (combinational, IDLE only)
//   m_araddr         master i address at [i*ADDR_W +: ADDR_W]
//   m_arlen          master i burst length at [i*LEN_W +: LEN_W]
//   m_arid           master i ID at [i*ID_W +: ID_W]
//   m_rvalid[1:0]    per-master R valid (owner only)
//   m_rready[1:0]    per-master R ready
//   m_rdata/rid/rresp/rlast  shared R payload
//   s_ar*            AR channel to the DRAM wrapper (registered fields)
//   s_arid           {grant index, master ID}
//   s_r*             R channel from the DRAM wrapper
// ---------------------------------------------------------------------------
module dram_rd_arbiter #(
   parameter int ID_W       = 4,
   parameter int LEN_W      = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            m_arvalid,
   output logic [1:0]            m_arready,
   input  logic [2*ADDR_W-1:0]   m_araddr,
   input  logic [2*LEN_W-1:0]    m_arlen,
   input  logic [2*ID_W-1:0]     m_arid,
   output logic [1:0]            m_rvalid,
   input  logic [1:0]            m_rready,
   output logic [DATA_W-1:0]     m_rdata,
   output logic [ID_W-1:0]       m_rid,
   output logic [1:0]            m_rresp,
   output logic                  m_rlast,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   output logic [ADDR_W-1:0]     s_araddr,
   output logic [LEN_W-1:0]      s_arlen,
   output logic [1:0]            s_arburst,
   output logic [2:0]            s_arsize,
   output logic [ID_W:0]         s_arid,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic [ID_W:0]         s_rid,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rlast
);

   localparam int SW = $clog2(MAX_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t state, state_nxt;

   logic              rr;
   logic              last_g;
   logic              owner;
   logic [SW-1:0]     streak;
   logic [SW-1:0]     streak_nxt;
   logic              row_valid;
   logic [10:0]       last_row;
   logic [ADDR_W-1:0] ar_addr;
   logic [LEN_W-1:0]  ar_len;
   logic [ID_W:0]     ar_id;

   logic [ADDR_W-1:0] addr0, addr1;
   logic [LEN_W-1:0]  len0, len1;
   logic [ID_W-1:0]   id0, id1;
   logic              hit0, hit1;
   logic              both;
   logic              grant;
   logic              g;

   // The grant index travels in s_rid's top bit, but routing uses the
   // registered owner, so that bit is intentionally not consumed.
   logic              unused_rid_msb;
   assign unused_rid_msb = s_rid[ID_W];

   assign addr0 = m_araddr[0 +: ADDR_W];
   assign addr1 = m_araddr[ADDR_W +: ADDR_W];
   assign len0  = m_arlen[0 +: LEN_W];
   assign len1  = m_arlen[LEN_W +: LEN_W];
   assign id0   = m_arid[0 +: ID_W];
   assign id1   = m_arid[ID_W +: ID_W];

   assign hit0  = m_arvalid[0] & row_valid & (addr0[24:14] == last_row);
   assign hit1  = m_arvalid[1] & row_valid & (addr1[24:14] == last_row);
   assign both  = &m_arvalid;
   assign grant = (state == IDLE) & (|m_arvalid);

   // Winner: lone requester, then starvation guard, then row hit, then rr.
   always_comb begin
      if (!both)
         g = m_arvalid[1];
      else if (streak >= STREAK_MAX)
         g = ~last_g;
      else if (hit0 ^ hit1)
         g = hit1;
      else
         g = rr;
   end

   // Streak only counts grants made while the other master was waiting.
   always_comb begin
      if (!both)
         streak_nxt = '0;
      else if (g != last_g)
         streak_nxt = SW'(1);
      else if (streak >= STREAK_MAX)
         streak_nxt = STREAK_MAX;
      else
         streak_nxt = streak + 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|m_arvalid) state_nxt = ADDR;
         ADDR:    if (s_arready) state_nxt = DATA;
         DATA:    if (s_rvalid && m_rready[owner] && s_rlast) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs; m_arready is masked during reset so no grant is offered
   // while the registers are being cleared.
   always_comb begin
      m_arready = '0;
      m_rvalid  = '0;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      case (state)
         IDLE: begin
            if (grant && !rst)
               m_arready[g] = 1'b1;
         end
         ADDR: begin
            s_arvalid = 1'b1;
         end
         DATA: begin
            m_rvalid[owner] = s_rvalid;
            s_rready        = m_rready[owner];
         end
         default: begin
            s_arvalid = 1'b0;
         end
      endcase
   end

   // Grant bookkeeping, captured AR fields and open-row tracker
   always_ff @(posedge clk) begin
      if (rst) begin
         rr        <= 1'b0;
         last_g    <= 1'b0;
         owner     <= 1'b0;
         streak    <= '0;
         row_valid <= 1'b0;
         last_row  <= '0;
         ar_addr   <= '0;
         ar_len    <= '0;
         ar_id     <= '0;
      end else begin
         if (grant) begin
            ar_addr <= g ? addr1 : addr0;
            ar_len  <= g ? len1 : len0;
            ar_id   <= {g, (g ? id1 : id0)};
            owner   <= g;
            rr      <= ~g;
            last_g  <= g;
            streak  <= streak_nxt;
         end
         if (state == ADDR && s_arready) begin
            row_valid <= 1'b1;
            last_row  <= ar_addr[24:14];
         end
      end
   end

   assign s_araddr  = ar_addr;
   assign s_arlen   = ar_len;
   assign s_arid    = ar_id;
   assign s_arburst = 2'b01;
   assign s_arsize  = 3'b010;

   assign m_rdata = s_rdata;
   assign m_rid   = s_rid[ID_W-1:0];
   assign m_rresp = s_rresp;
   assign m_rlast = s_rlast;

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_rd_arbiter
//
// Scoreboard bench for dram_rd_arbiter. Directed requests are queued per
// master; the expected grant order, AR fields and R beats are pushed into
// scoreboard queues at issue time. A monitor pops and compares whenever the
// DUT shows a grant, an AR handshake or an R handshake. A simple DRAM model
// answers each AR with len+1 beats whose data is derived from the address.
// Inputs change on the falling edge; observation happens 1 ns before the
// rising edge.
// ---------------------------------------------------------------------------
module tb_dram_rd_arbiter;

   localparam int ID_W = 4, LEN_W = 4, ADDR_W = 32, DATA_W = 32, MAX_STREAK = 4;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]          m_arvalid, m_arready, m_rvalid, m_rready;
   logic [2*ADDR_W-1:0] m_araddr;
   logic [2*LEN_W-1:0]  m_arlen;
   logic [2*ID_W-1:0]   m_arid;
   logic [DATA_W-1:0]   m_rdata;
   logic [ID_W-1:0]     m_rid;
   logic [1:0]          m_rresp;
   logic                m_rlast;
   logic                s_arvalid, s_arready;
   logic [ADDR_W-1:0]   s_araddr;
   logic [LEN_W-1:0]    s_arlen;
   logic [1:0]          s_arburst;
   logic [2:0]          s_arsize;
   logic [ID_W:0]       s_arid;
   logic                s_rvalid, s_rready;
   logic [DATA_W-1:0]   s_rdata;
   logic [ID_W:0]       s_rid;
   logic [1:0]          s_rresp;
   logic                s_rlast;

   always #5 clk = ~clk;

   dram_rd_arbiter #(
      .ID_W(ID_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(MAX_STREAK)
   ) dut (
      .clk(clk), .rst(rst),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arid(m_arid),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_arlen(s_arlen), .s_arburst(s_arburst), .s_arsize(s_arsize), .s_arid(s_arid),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast)
   );

   typedef struct { logic [31:0] addr; logic [3:0] len; logic [3:0] id; } req_t;
   typedef struct { logic [31:0] addr; logic [3:0] len; logic [4:0] arid; } ar_t;
   typedef struct { logic [1:0] rv; logic [31:0] data; logic [3:0] id; logic [1:0] resp; logic last; } beat_t;

   req_t  q0[$], q1[$];
   int    exp_g[$];
   ar_t   exp_ar[$];
   beat_t exp_r[$];

   int total = 0;
   int bad   = 0;
   int r_count = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input int m, input logic [31:0] a, input logic [3:0] l, input logic [3:0] id);
      req_t r;
      r.addr = a; r.len = l; r.id = id;
      if (m == 0) q0.push_back(r);
      else        q1.push_back(r);
   endtask

   task automatic expect_burst(input int g, input logic [31:0] a, input logic [3:0] l,
                               input logic [3:0] id, input int nbeats);
      ar_t   x;
      beat_t b;
      exp_g.push_back(g);
      x.addr = a; x.len = l; x.arid = {g[0], id};
      exp_ar.push_back(x);
      for (int k = 0; k < nbeats; k++) begin
         b.rv   = (g == 0) ? 2'b01 : 2'b10;
         b.data = a ^ (32'hD000_0000 | 32'(k));
         b.id   = id;
         b.resp = 2'(k);
         b.last = (k == int'(l));
         exp_r.push_back(b);
      end
   endtask

   // ---------------- master drivers ----------------
   logic [1:0] m_fire;
   logic       m_rs;
   initial begin
      req_t r;
      m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arid = '0;
      m_fire = '0; m_rs = 1'b1;
      forever begin
         @(negedge clk);
         if (m_rs) begin
            m_arvalid = '0;
         end else begin
            if (m_fire[0]) m_arvalid[0] = 1'b0;
            if (m_fire[1]) m_arvalid[1] = 1'b0;
            if (!m_arvalid[0] && q0.size() != 0) begin
               r = q0.pop_front();
               m_araddr[31:0] = r.addr; m_arlen[3:0] = r.len; m_arid[3:0] = r.id;
               m_arvalid[0] = 1'b1;
            end
            if (!m_arvalid[1] && q1.size() != 0) begin
               r = q1.pop_front();
               m_araddr[63:32] = r.addr; m_arlen[7:4] = r.len; m_arid[7:4] = r.id;
               m_arvalid[1] = 1'b1;
            end
         end
         #4;
         m_fire = m_arvalid & m_arready;
         m_rs   = rst;
      end
   end

   // ---------------- DRAM wrapper model ----------------
   logic        sl_busy, sl_ar_fire, sl_r_fire, sl_rs;
   logic [31:0] sl_addr;
   logic [4:0]  sl_id;
   int          sl_left, sl_beat;
   initial begin
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 1'b0;
      sl_busy = 1'b0; sl_ar_fire = 1'b0; sl_r_fire = 1'b0; sl_rs = 1'b1;
      sl_addr = '0; sl_id = '0; sl_left = 0; sl_beat = 0;
      forever begin
         @(negedge clk);
         if (sl_rs) begin
            sl_busy = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
         end else begin
            if (sl_r_fire) begin
               sl_left--; sl_beat++;
            end
            if (sl_ar_fire) begin
               sl_busy = 1'b1; s_arready = 1'b0;
               sl_addr = s_araddr; sl_id = s_arid;
               sl_left = int'(s_arlen) + 1; sl_beat = 0;
            end else if (!sl_busy) begin
               s_arready = s_arvalid;
            end
            if (sl_busy && sl_left == 0) begin
               sl_busy = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
            end else if (sl_busy) begin
               s_rvalid = 1'b1;
               s_rdata  = sl_addr ^ (32'hD000_0000 | 32'(sl_beat));
               s_rid    = sl_id;
               s_rresp  = 2'(sl_beat);
               s_rlast  = (sl_left == 1);
            end
         end
         #4;
         sl_ar_fire = s_arvalid & s_arready;
         sl_r_fire  = s_rvalid & s_rready;
         sl_rs      = rst;
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      int    g;
      ar_t   x;
      beat_t b;
      forever begin
         @(negedge clk);
         #4;
         if (!rst) begin
            if (m_arready != 2'b00) begin
               if (exp_g.size() == 0) begin
                  total++; bad++;
                  $display("FAIL grant_unexpected: got %b expected none", m_arready);
               end else begin
                  g = exp_g.pop_front();
                  chk("grant", 64'(m_arready), (g == 0) ? 64'h1 : 64'h2);
               end
            end
            if (s_arvalid && s_arready) begin
               if (exp_ar.size() == 0) begin
                  total++; bad++;
                  $display("FAIL ar_unexpected: got addr %0h expected none", s_araddr);
               end else begin
                  x = exp_ar.pop_front();
                  chk("ar_addr", 64'(s_araddr), 64'(x.addr));
                  chk("ar_len", 64'(s_arlen), 64'(x.len));
                  chk("ar_id", 64'(s_arid), 64'(x.arid));
                  chk("ar_burst_size", 64'({s_arburst, s_arsize}), 64'h0A);
               end
            end
            if (s_rvalid && s_rready) begin
               r_count++;
               if (exp_r.size() == 0) begin
                  total++; bad++;
                  $display("FAIL beat_unexpected: got data %0h expected none", m_rdata);
               end else begin
                  b = exp_r.pop_front();
                  chk("r_valid", 64'(m_rvalid), 64'(b.rv));
                  chk("r_data", 64'(m_rdata), 64'(b.data));
                  chk("r_id", 64'(m_rid), 64'(b.id));
                  chk("r_resp", 64'(m_rresp), 64'(b.resp));
                  chk("r_last", 64'(m_rlast), 64'(b.last));
               end
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_g.size() != 0 || exp_ar.size() != 0 || exp_r.size() != 0 || sl_busy ||
              m_arvalid != 2'b00 || q0.size() != 0 || q1.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 400) begin
         bad++;
         $display("FAIL %s: timeout, grants left %0d beats left %0d expected 0", name,
                  exp_g.size(), exp_r.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_beats(input int target, input string name);
      int n = 0;
      while (r_count < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (r_count < target) begin
         bad++;
         $display("FAIL %s: timeout, beats %0d expected %0d", name, r_count, target);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_m_arready"}, 64'(m_arready), 64'h0);
      chk({name, "_m_rvalid"},  64'(m_rvalid),  64'h0);
      chk({name, "_s_arvalid"}, 64'(s_arvalid), 64'h0);
      chk({name, "_s_rready"},  64'(s_rready),  64'h0);
      chk({name, "_s_araddr"},  64'(s_araddr),  64'h0);
      chk({name, "_s_arlen"},   64'(s_arlen),   64'h0);
      chk({name, "_s_arid"},    64'(s_arid),    64'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int base;
      rst = 1'b1;
      m_rready = 2'b11;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Both valid straight out of reset: no open row, rr=0 -> 0 then 1.
      issue(0, 32'h0001_0000, 4'd1, 4'h1);
      issue(1, 32'h0002_0000, 4'd1, 4'h2);
      expect_burst(0, 32'h0001_0000, 4'd1, 4'h1, 2);
      expect_burst(1, 32'h0002_0000, 4'd1, 4'h2, 2);
      wait_drain("both_from_reset");

      // Single master 0 burst opens row 1.
      do_reset();
      issue(0, 32'h0000_4000, 4'd3, 4'h3);
      expect_burst(0, 32'h0000_4000, 4'd3, 4'h3, 4);
      wait_drain("single_m0");

      // Master 1 hits row 1 four times, then master 0 (row 2) is forced in.
      issue(0, 32'h0000_8000, 4'd0, 4'h4);
      issue(1, 32'h0000_4010, 4'd0, 4'h5);
      issue(1, 32'h0000_4020, 4'd0, 4'h6);
      issue(1, 32'h0000_4030, 4'd0, 4'h7);
      issue(1, 32'h0000_4040, 4'd0, 4'h8);
      issue(1, 32'h0000_4050, 4'd0, 4'h9);
      expect_burst(1, 32'h0000_4010, 4'd0, 4'h5, 1);
      expect_burst(1, 32'h0000_4020, 4'd0, 4'h6, 1);
      expect_burst(1, 32'h0000_4030, 4'd0, 4'h7, 1);
      expect_burst(1, 32'h0000_4040, 4'd0, 4'h8, 1);
      expect_burst(0, 32'h0000_8000, 4'd0, 4'h4, 1);
      expect_burst(1, 32'h0000_4050, 4'd0, 4'h9, 1);
      wait_drain("row_hit_streak");

      // Owner backpressure for 3 cycles after the first beat.
      base = r_count;
      issue(1, 32'h0000_C000, 4'd3, 4'hA);
      expect_burst(1, 32'h0000_C000, 4'd3, 4'hA, 4);
      wait_beats(base + 1, "bp_first_beat");
      m_rready = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #4;
         chk("bp_s_rready", 64'(s_rready), 64'h0);
         chk("bp_m_rvalid", 64'(m_rvalid), 64'h2);
         @(negedge clk);
      end
      m_rready = 2'b11;
      wait_drain("backpressure");

      // Reset in DATA after 2 of 4 beats, then a normal grant.
      base = r_count;
      issue(0, 32'h0000_4000, 4'd3, 4'h6);
      expect_burst(0, 32'h0000_4000, 4'd3, 4'h6, 2);
      wait_beats(base + 2, "midburst_two_beats");
      m_rready = 2'b00;
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_reset_outputs("midburst_rst");
      @(negedge clk);
      rst = 1'b0;
      m_rready = 2'b11;
      issue(1, 32'h0000_2000, 4'd0, 4'h7);
      expect_burst(1, 32'h0000_2000, 4'd0, 4'h7, 1);
      wait_drain("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
